// File: rtl/pattern_pkg.sv
// Shared constants, field offsets and load-FSM state type
// for the pattern buffer load controller.
package pattern_pkg;

   localparam int NO_FIELDS    = 22;
   localparam int NO_BUFS      = 8;
   localparam int BUFFER_WIDTH = 8;

   localparam logic [4:0] PDRIVE  = 5'd0;
   localparam logic [4:0] NDRIVE  = 5'd1;
   localparam logic [4:0] PSLEW   = 5'd2;
   localparam logic [4:0] NSLEW   = 5'd3;
   localparam logic [4:0] PTERM   = 5'd4;
   localparam logic [4:0] NTERM   = 5'd5;
   localparam logic [4:0] PVREF   = 5'd6;
   localparam logic [4:0] NVREF   = 5'd7;
   localparam logic [4:0] PDLY0   = 5'd8;
   localparam logic [4:0] PDLY1   = 5'd9;
   localparam logic [4:0] PDLY2   = 5'd10;
   localparam logic [4:0] NDLY0   = 5'd11;
   localparam logic [4:0] NDLY1   = 5'd12;
   localparam logic [4:0] NDLY2   = 5'd13;
   localparam logic [4:0] PTWEAK0 = 5'd14;
   localparam logic [4:0] PTWEAK1 = 5'd15;
   localparam logic [4:0] PTWEAK2 = 5'd16;
   localparam logic [4:0] PTWEAK3 = 5'd17;
   localparam logic [4:0] NTWEAK0 = 5'd18;
   localparam logic [4:0] NTWEAK1 = 5'd19;
   localparam logic [4:0] NTWEAK2 = 5'd20;
   localparam logic [4:0] NTWEAK3 = 5'd21;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } load_state_e;

endpackage

// File: rtl/pattern_load_ctrl_if.sv
// Core-write, bulk-load and pattern-buffer write-port bundle.
// master: requester/consumer side; slave: pattern_load_ctrl.
interface pattern_load_if #(
   parameter int BW = 8
);
   logic          p_req;
   logic [2:0]    p_buf;
   logic [4:0]    p_field;
   logic [BW-1:0] p_data;
   logic          p_gnt;
   logic          b_start;
   logic [2:0]    b_buf;
   logic [BW-1:0] b_data;
   logic          b_valid;
   logic          b_ready;
   logic          b_busy;
   logic          b_done;
   logic [BW-1:0] checksum;
   logic [2:0]    bufp_out;
   logic [4:0]    fieldwp_out;
   logic [BW-1:0] field_in_out;
   logic          field_write_out;

   modport master (
      output p_req, p_buf, p_field, p_data,
      output b_start, b_buf, b_data, b_valid,
      input  p_gnt, b_ready, b_busy, b_done,
      input  checksum, bufp_out, fieldwp_out,
      input  field_in_out, field_write_out
   );

   modport slave (
      input  p_req, p_buf, p_field, p_data,
      input  b_start, b_buf, b_data, b_valid,
      output p_gnt, b_ready, b_busy, b_done,
      output checksum, bufp_out, fieldwp_out,
      output field_in_out, field_write_out
   );

endinterface

// File: rtl/load_arb2.sv
// Two-way round-robin arbiter. req[0]=bulk, req[1]=core.
// last=1: core served last, so bulk wins a conflict. gnt one-hot.
module load_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req[0] & (~req[1] | last);
      gnt[1] = req[1] & (~req[0] | ~last);
   end

endmodule

// File: rtl/pattern_load_ctrl.sv
// Pattern buffer load controller: merges core single writes and
// bulk bursts onto one registered pattern-buffer write port.
// Ports: clk, reset (async, active high), bus (pattern_load_if.slave).
// Optional macro LOAD_CHECKSUM_EN: running XOR of burst bytes.
module pattern_load_ctrl
   import pattern_pkg::*;
#(
   parameter int buffer_width = BUFFER_WIDTH,
   parameter int no_fields    = NO_FIELDS,
   parameter int no_bufs      = NO_BUFS
) (
   input  logic clk,
   input  logic reset,
   pattern_load_if.slave bus
);

   localparam int BUF_W = $clog2(no_bufs);
   localparam logic [4:0] FIELD_LIM = 5'(no_fields);
   localparam logic [4:0] LAST_CNT  = 5'(no_fields - 1);

   load_state_e state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [BUF_W-1:0] buf_q, buf_d;
   logic             last_core_q, last_core_d;

   logic [2:0]              bufp_q, bufp_d;
   logic [4:0]              fwp_q, fwp_d;
   logic [buffer_width-1:0] fin_q, fin_d;
   logic                    we_q, we_d;

   logic [1:0] arb_req;
   logic [1:0] arb_gnt;
   logic       core_gnt;
   logic       bulk_acc;

   assign arb_req = {bus.p_req, bus.b_valid};

   load_arb2 u_arb (
      .req  (arb_req),
      .last (last_core_q),
      .gnt  (arb_gnt)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      last_core_d = last_core_q;
      core_gnt    = 1'b0;
      bulk_acc    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.b_start) begin
               state_d = S_BURST;
               buf_d   = bus.b_buf;
               cnt_d   = '0;
            end else begin
               core_gnt = bus.p_req;
            end
         end
         S_BURST: begin
            core_gnt = arb_gnt[1];
            bulk_acc = arb_gnt[0];
            if (bulk_acc) begin
               // hold at the last index, never wrap
               if (cnt_q == LAST_CNT)
                  state_d = S_DONE;
               else
                  cnt_d = cnt_q + 5'd1;
            end
         end
         S_DONE: begin
            core_gnt = bus.p_req;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (core_gnt)
         last_core_d = 1'b1;
      else if (bulk_acc)
         last_core_d = 1'b0;
   end

   always_comb begin
      bufp_d = bufp_q;
      fwp_d  = fwp_q;
      fin_d  = fin_q;
      we_d   = 1'b0;
      if (bulk_acc) begin
         bufp_d = buf_q;
         fwp_d  = cnt_q;
         fin_d  = bus.b_data;
         we_d   = 1'b1;
      end else if (core_gnt && bus.p_field < FIELD_LIM) begin
         // out-of-range fields are granted but dropped
         bufp_d = bus.p_buf;
         fwp_d  = bus.p_field;
         fin_d  = bus.p_data;
         we_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         buf_q       <= '0;
         last_core_q <= 1'b1;
         bufp_q      <= '0;
         fwp_q       <= '0;
         fin_q       <= '0;
         we_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         last_core_q <= last_core_d;
         bufp_q      <= bufp_d;
         fwp_q       <= fwp_d;
         fin_q       <= fin_d;
         we_q        <= we_d;
      end
   end

`ifdef LOAD_CHECKSUM_EN
   logic [buffer_width-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (state_q == S_IDLE && bus.b_start)
         sum_d = '0;
      else if (bulk_acc)
         sum_d = sum_q ^ bus.b_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sum_q <= '0;
      else
         sum_q <= sum_d;
   end

   assign bus.checksum = sum_q;
`else
   assign bus.checksum = '0;
`endif

   // grant is combinational, so mask it while reset is held
   assign bus.p_gnt   = core_gnt & ~reset;
   assign bus.b_ready = (state_q == S_BURST) & ~core_gnt;
   assign bus.b_busy  = (state_q == S_BURST);
   assign bus.b_done  = (state_q == S_DONE);

   assign bus.bufp_out        = bufp_q;
   assign bus.fieldwp_out     = fwp_q;
   assign bus.field_in_out    = fin_q;
   assign bus.field_write_out = we_q;

endmodule

// File: tb/tb_pattern_load_ctrl.sv
// Directed self-checking bench for pattern_load_ctrl.
// Honours LOAD_CHECKSUM_EN for the expected checksum.
module tb_pattern_load_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

`ifdef LOAD_CHECKSUM_EN
   localparam logic [7:0] EXP_SUM = 8'h01;
`else
   localparam logic [7:0] EXP_SUM = 8'h00;
`endif

   pattern_load_if #(.BW(8)) bus ();

   pattern_load_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.p_req   = 1'b0;
      bus.p_buf   = 3'd0;
      bus.p_field = 5'd0;
      bus.p_data  = 8'h00;
      bus.b_start = 1'b0;
      bus.b_buf   = 3'd0;
      bus.b_data  = 8'h00;
      bus.b_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      tests++;
      if ({bus.p_gnt, bus.b_ready, bus.b_busy, bus.b_done,
           bus.field_write_out} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl got %b want 00000",
                  {bus.p_gnt, bus.b_ready, bus.b_busy,
                   bus.b_done, bus.field_write_out});
      end
      tests++;
      if (bus.checksum !== 8'h00 || bus.bufp_out !== 3'd0 ||
          bus.fieldwp_out !== 5'd0 || bus.field_in_out !== 8'h00) begin
         fails++;
         $display("FAIL reset_data got sum=%h b=%0d f=%0d d=%h want 0",
                  bus.checksum, bus.bufp_out, bus.fieldwp_out,
                  bus.field_in_out);
      end
      reset = 1'b0;
      step();
      tests++;
      if (bus.b_busy !== 1'b0 || bus.field_write_out !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle got busy=%b we=%b want 0 0",
                  bus.b_busy, bus.field_write_out);
      end
   endtask

   task automatic test_core_write();
      bus.p_req   = 1'b1;
      bus.p_buf   = 3'd3;
      bus.p_field = 5'd5;
      bus.p_data  = 8'hA5;
      #1;
      tests++;
      if (bus.p_gnt !== 1'b1) begin
         fails++;
         $display("FAIL core_gnt got %b want 1", bus.p_gnt);
      end
      step();
      bus.p_req = 1'b0;
      tests++;
      if (bus.field_write_out !== 1'b1 || bus.bufp_out !== 3'd3 ||
          bus.fieldwp_out !== 5'd5 || bus.field_in_out !== 8'hA5) begin
         fails++;
         $display("FAIL core_write got we=%b b=%0d f=%0d d=%h want 1 3 5 a5",
                  bus.field_write_out, bus.bufp_out, bus.fieldwp_out,
                  bus.field_in_out);
      end
      step();
      tests++;
      if (bus.field_write_out !== 1'b0 || bus.bufp_out !== 3'd3 ||
          bus.fieldwp_out !== 5'd5 || bus.field_in_out !== 8'hA5) begin
         fails++;
         $display("FAIL core_hold got we=%b b=%0d f=%0d d=%h want 0 3 5 a5",
                  bus.field_write_out, bus.bufp_out, bus.fieldwp_out,
                  bus.field_in_out);
      end
   endtask

   task automatic test_drop_field();
      bus.p_req   = 1'b1;
      bus.p_buf   = 3'd1;
      bus.p_field = 5'd22;
      bus.p_data  = 8'hEE;
      #1;
      tests++;
      if (bus.p_gnt !== 1'b1) begin
         fails++;
         $display("FAIL drop_gnt got %b want 1", bus.p_gnt);
      end
      step();
      bus.p_req = 1'b0;
      tests++;
      if (bus.field_write_out !== 1'b0 || bus.bufp_out !== 3'd3 ||
          bus.fieldwp_out !== 5'd5 || bus.field_in_out !== 8'hA5) begin
         fails++;
         $display("FAIL drop_nostrobe got we=%b b=%0d f=%0d d=%h want 0 3 5 a5",
                  bus.field_write_out, bus.bufp_out, bus.fieldwp_out,
                  bus.field_in_out);
      end
   endtask

   task automatic test_clean_burst();
      logic exp_done;
      bus.b_start = 1'b1;
      bus.b_buf   = 3'd6;
      #1;
      tests++;
      if (bus.b_ready !== 1'b0 || bus.b_busy !== 1'b0) begin
         fails++;
         $display("FAIL burst_idle got rdy=%b busy=%b want 0 0",
                  bus.b_ready, bus.b_busy);
      end
      step();
      bus.b_start = 1'b0;
      tests++;
      if (bus.b_busy !== 1'b1) begin
         fails++;
         $display("FAIL burst_busy got %b want 1", bus.b_busy);
      end
      for (int i = 0; i < 22; i++) begin
         bus.b_valid = 1'b1;
         bus.b_data  = 8'(i);
         bus.b_start = (i == 5);
         bus.b_buf   = (i == 5) ? 3'd2 : 3'd6;
         #1;
         tests++;
         if (bus.b_ready !== 1'b1) begin
            fails++;
            $display("FAIL burst_ready[%0d] got %b want 1", i, bus.b_ready);
         end
         step();
         tests++;
         if (bus.field_write_out !== 1'b1 || bus.bufp_out !== 3'd6 ||
             bus.fieldwp_out !== 5'(i) || bus.field_in_out !== 8'(i)) begin
            fails++;
            $display("FAIL burst_beat[%0d] got we=%b b=%0d f=%0d d=%h want 1 6 %0d %0d",
                     i, bus.field_write_out, bus.bufp_out,
                     bus.fieldwp_out, bus.field_in_out, i, i);
         end
         exp_done = (i == 21);
         tests++;
         if (bus.b_done !== exp_done) begin
            fails++;
            $display("FAIL burst_done[%0d] got %b want %b",
                     i, bus.b_done, exp_done);
         end
      end
      bus.b_valid = 1'b0;
      bus.b_start = 1'b1;
      bus.b_buf   = 3'd2;
      #1;
      tests++;
      if (bus.checksum !== EXP_SUM || bus.b_busy !== 1'b0) begin
         fails++;
         $display("FAIL burst_sum got sum=%h busy=%b want %h 0",
                  bus.checksum, bus.b_busy, EXP_SUM);
      end
      step();
      bus.b_start = 1'b0;
      tests++;
      if (bus.b_done !== 1'b0 || bus.b_busy !== 1'b0 ||
          bus.field_write_out !== 1'b0 || bus.checksum !== EXP_SUM) begin
         fails++;
         $display("FAIL burst_after got done=%b busy=%b we=%b sum=%h want 0 0 0 %h",
                  bus.b_done, bus.b_busy, bus.field_write_out,
                  bus.checksum, EXP_SUM);
      end
   endtask

   task automatic test_start_vs_core();
      bus.p_req   = 1'b1;
      bus.p_buf   = 3'd2;
      bus.p_field = 5'd9;
      bus.p_data  = 8'h5A;
      bus.b_start = 1'b1;
      bus.b_buf   = 3'd4;
      #1;
      tests++;
      if (bus.p_gnt !== 1'b0) begin
         fails++;
         $display("FAIL start_wins got p_gnt=%b want 0", bus.p_gnt);
      end
      step();
      bus.b_start = 1'b0;
      #1;
      tests++;
      if (bus.p_gnt !== 1'b1 || bus.b_busy !== 1'b1 ||
          bus.b_ready !== 1'b0) begin
         fails++;
         $display("FAIL core_next got gnt=%b busy=%b rdy=%b want 1 1 0",
                  bus.p_gnt, bus.b_busy, bus.b_ready);
      end
      step();
      bus.p_req = 1'b0;
      tests++;
      if (bus.field_write_out !== 1'b1 || bus.bufp_out !== 3'd2 ||
          bus.fieldwp_out !== 5'd9 || bus.field_in_out !== 8'h5A) begin
         fails++;
         $display("FAIL core_in_burst got we=%b b=%0d f=%0d d=%h want 1 2 9 5a",
                  bus.field_write_out, bus.bufp_out, bus.fieldwp_out,
                  bus.field_in_out);
      end
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i <= 10; i++) begin
         bus.b_valid = 1'b1;
         bus.b_data  = 8'(8'h10 + i);
         step();
      end
      bus.b_valid = 1'b0;
      tests++;
      if (bus.field_write_out !== 1'b1 || bus.fieldwp_out !== 5'd10 ||
          bus.bufp_out !== 3'd4 || bus.field_in_out !== 8'h1A) begin
         fails++;
         $display("FAIL beat10 got we=%b b=%0d f=%0d d=%h want 1 4 10 1a",
                  bus.field_write_out, bus.bufp_out, bus.fieldwp_out,
                  bus.field_in_out);
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({bus.field_write_out, bus.b_busy, bus.b_done, bus.b_ready,
           bus.p_gnt} !== 5'b0 || bus.bufp_out !== 3'd0 ||
          bus.fieldwp_out !== 5'd0 || bus.field_in_out !== 8'h00 ||
          bus.checksum !== 8'h00) begin
         fails++;
         $display("FAIL mid_reset got we=%b busy=%b done=%b b=%0d f=%0d d=%h sum=%h want 0",
                  bus.field_write_out, bus.b_busy, bus.b_done,
                  bus.bufp_out, bus.fieldwp_out, bus.field_in_out,
                  bus.checksum);
      end
      step();
      reset = 1'b0;
      step();
      tests++;
      if (bus.field_write_out !== 1'b0 || bus.b_done !== 1'b0) begin
         fails++;
         $display("FAIL no_reissue got we=%b done=%b want 0 0",
                  bus.field_write_out, bus.b_done);
      end
      bus.b_start = 1'b1;
      bus.b_buf   = 3'd5;
      step();
      bus.b_start = 1'b0;
      bus.b_valid = 1'b1;
      bus.b_data  = 8'h77;
      step();
      bus.b_valid = 1'b0;
      tests++;
      if (bus.field_write_out !== 1'b1 || bus.fieldwp_out !== 5'd0 ||
          bus.bufp_out !== 3'd5 || bus.field_in_out !== 8'h77) begin
         fails++;
         $display("FAIL restart got we=%b b=%0d f=%0d d=%h want 1 5 0 77",
                  bus.field_write_out, bus.bufp_out, bus.fieldwp_out,
                  bus.field_in_out);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_contention();
      logic exp_core;
      int   beats;
      int   strobes;
      exp_core = 1'b0;
      beats    = 0;
      strobes  = 0;
      bus.b_start = 1'b1;
      bus.b_buf   = 3'd1;
      step();
      bus.b_start = 1'b0;
      bus.p_req   = 1'b1;
      bus.p_buf   = 3'd2;
      bus.p_field = 5'd7;
      bus.p_data  = 8'h3C;
      bus.b_valid = 1'b1;
      for (int c = 0; c < 43; c++) begin
         bus.b_data = 8'(beats);
         #1;
         tests++;
         if (bus.p_gnt !== exp_core || bus.b_ready !== !exp_core) begin
            fails++;
            $display("FAIL rr_grant[%0d] got gnt=%b rdy=%b want %b %b",
                     c, bus.p_gnt, bus.b_ready, exp_core, !exp_core);
         end
         step();
         if (bus.field_write_out === 1'b1) strobes++;
         tests++;
         if (!exp_core) begin
            if (bus.fieldwp_out !== 5'(beats) || bus.bufp_out !== 3'd1 ||
                bus.field_in_out !== 8'(beats)) begin
               fails++;
               $display("FAIL rr_bulk[%0d] got b=%0d f=%0d d=%h want 1 %0d %0d",
                        c, bus.bufp_out, bus.fieldwp_out,
                        bus.field_in_out, beats, beats);
            end
            beats++;
         end else begin
            if (bus.fieldwp_out !== 5'd7 || bus.bufp_out !== 3'd2 ||
                bus.field_in_out !== 8'h3C) begin
               fails++;
               $display("FAIL rr_core[%0d] got b=%0d f=%0d d=%h want 2 7 3c",
                        c, bus.bufp_out, bus.fieldwp_out,
                        bus.field_in_out);
            end
         end
         exp_core = !exp_core;
      end
      bus.b_valid = 1'b0;
      #1;
      tests++;
      if (bus.b_done !== 1'b1 || bus.p_gnt !== 1'b1) begin
         fails++;
         $display("FAIL rr_done got done=%b gnt=%b want 1 1",
                  bus.b_done, bus.p_gnt);
      end
      step();
      bus.p_req = 1'b0;
      if (bus.field_write_out === 1'b1) strobes++;
      step();
      if (bus.field_write_out === 1'b1) strobes++;
      tests++;
      if (strobes != 44) begin
         fails++;
         $display("FAIL rr_strobes got %0d want 44", strobes);
      end
   endtask

   initial begin
      test_reset();
      test_core_write();
      test_drop_field();
      test_clean_burst();
      test_start_vs_core();
      test_reset_mid_burst();
      test_contention();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pattern_load_ctrl.md
PATTERN_LOAD_CTRL -- requirements
Module: pattern_load_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be, one per line:
- buffer_width, 8, field byte width.
- no_fields, 22, fields per buffer.
- no_bufs, 8, number of pattern buffers.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- p_req  in  1  core single-write request
- p_buf  in  3  core target buffer
- p_field  in  5  core target field
- p_data  in  buffer_width  core write data
- p_gnt  out  1  core write accepted this cycle
- b_start  in  1  bulk-load start pulse
- b_buf  in  3  bulk target buffer
- b_data  in  buffer_width  bulk beat data
- b_valid  in  1  bulk beat valid
- b_ready  out  1  bulk beat accepted when high with b_valid
- b_busy  out  1  burst in progress
- b_done  out  1  one-cycle pulse after the last beat is issued
- checksum  out  buffer_width  XOR of burst bytes
- bufp_out  out  3  write buffer index to patternbuffer
- fieldwp_out  out  5  write field index
- field_in_out  out  buffer_width  write data
- field_write_out  out  1  write strobe

Function
REQ-004 The FSM SHALL have three states: IDLE, BURST and DONE.
REQ-005 IDLE SHALL behave as follows:
- b_start SHALL latch b_buf, clear the field counter and checksum, and go to BURST.
- p_req without b_start SHALL be granted in the same cycle.
- b_start and p_req together: b_start SHALL win and p_req SHALL wait.
REQ-006 BURST SHALL arbitrate as follows:
- b_valid alone SHALL be accepted; p_req alone SHALL be granted.
- When both are high, the requester not served last SHALL be granted, using a round-robin last-grant bit.
REQ-007 The last-grant bit SHALL reset to core, so bulk wins the first conflict.
REQ-008 An accepted bulk beat SHALL write field index = counter into the latched buffer, then increment the counter.
REQ-009 When the counter reaches no_fields-1, the FSM SHALL go to DONE; the counter SHALL never wrap to 0 within a burst.
REQ-010 DONE SHALL last one cycle: b_done=1, then return to IDLE; p_req SHALL be grantable in DONE.
REQ-011 b_start SHALL be ignored in BURST and in DONE.
REQ-012 b_ready SHALL equal (state==BURST) and not (p_gnt this cycle).
REQ-013 p_gnt SHALL be combinational from the current state and inputs, at most one grant per cycle.
REQ-014 Write-port outputs SHALL be registered, appearing exactly 1 cycle after the grant or accept; field_write_out SHALL be high for exactly 1 cycle per accepted transaction.
REQ-015 With no grant, field_write_out SHALL be 0 and bufp_out, fieldwp_out and field_in_out SHALL hold their previous values.
REQ-016 A p_field value of no_fields or greater SHALL be granted but SHALL NOT strobe (dropped).
REQ-017 b_busy SHALL be high in BURST only.

Reset
REQ-018 Reset SHALL immediately put the block in IDLE with:
- field counter=0, last-grant=core.
- all outputs 0, including checksum.
REQ-019 Reset mid-burst SHALL abandon the burst with no b_done; a write registered before reset SHALL NOT be re-issued.

Configuration
REQ-020 With LOAD_CHECKSUM_EN defined:
- checksum SHALL be the running XOR of accepted bulk bytes, cleared on burst start.
- checksum SHALL be stable from b_done until the next b_start.
REQ-021 Without LOAD_CHECKSUM_EN, checksum SHALL be constant 0 and no checksum register SHALL exist.

Structure
REQ-022 Shared package pattern_pkg SHALL hold:
- NO_FIELDS=22, NO_BUFS=8, BUFFER_WIDTH=8.
- the field-offset constants (PDRIVE..NTWEAK3).
- the load-FSM state typedef.
REQ-023 The two-way round-robin grant SHALL be sub-module load_arb2 (inputs: two requests and last-grant; outputs: one-hot grant).

Verification
REQ-024 Core-only write: p_req=1, p_buf=3, p_field=5, p_data=0xA5 -> p_gnt same cycle; next cycle field_write_out=1, bufp_out=3, fieldwp_out=5, field_in_out=0xA5.
REQ-025 Clean burst: b_start with b_buf=6, then 22 beats of data=index -> fieldwp_out 0..21 in order, all with bufp_out=6; b_done 1 cycle after the 22nd beat; with LOAD_CHECKSUM_EN, checksum=0x01.
REQ-026 Contention: p_req and b_valid held high through a burst -> grants alternate bulk, core, bulk...; 44 strobes in total; b_ready low on core cycles.
REQ-027 Simultaneous b_start and p_req in IDLE -> burst starts and p_gnt=0 that cycle; p_gnt=1 the next cycle.
REQ-028 Reset asserted after beat 10 -> outputs 0 immediately, no b_done, next b_start restarts at field 0.
REQ-029 p_field=22 -> p_gnt=1 and no field_write_out pulse.
